// File: rtl/snake_dir_ctrl.sv
// Snake head direction controller: filters illegal turns, buffers accepted
// turns in a small FIFO and applies one turn per movement tick.
module snake_dir_ctrl #(
  parameter int unsigned QDEPTH   = 2,
  parameter logic [1:0]  INIT_DIR = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       tick,
  input  logic       game_run,
  input  logic       restart,
  output logic [1:0] dir,
  output logic       step,
  output logic [2:0] q_count,
  output logic       drop
);

  localparam int unsigned     PW   = (QDEPTH > 2) ? 2 : 1;
  localparam logic [PW-1:0]   PMAX = PW'(QDEPTH - 1);
  localparam logic [2:0]      QMAX = 3'(QDEPTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  logic          step_q, step_d;
  logic          drop_q, drop_d;
  logic [2:0]    count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0]    mem_q [QDEPTH];

  logic          active, any_key, pop, push, reject;
  logic [1:0]    key_dir, ref_dir;
  logic [PW-1:0] tail_ptr;

  // A falling game_run masks the tick/key of that same cycle.
  assign active  = (state_q == RUN) && game_run;
  assign any_key = key_up | key_down | key_left | key_right;

  always_comb begin
    key_dir = 2'b11;
    if (key_up)        key_dir = 2'b00;
    else if (key_down) key_dir = 2'b01;
    else if (key_left) key_dir = 2'b10;
  end

  assign tail_ptr = (wr_ptr_q == '0) ? PMAX : wr_ptr_q - PW'(1);
  assign ref_dir  = (count_q != 3'd0) ? mem_q[tail_ptr] : dir_q;

  assign pop    = active && tick && (count_q != 3'd0);
  assign reject = (key_dir == ref_dir)
               || ((key_dir[1] == ref_dir[1]) && (key_dir[0] != ref_dir[0]))
               || ((count_q == QMAX) && !pop);
  assign push   = active && any_key && !reject;

  // NOTE: all next-state values get a default first so no latch is inferred.
  always_comb begin
    state_d  = game_run ? RUN : IDLE;
    dir_d    = dir_q;
    step_d   = active && tick;
    drop_d   = active && any_key && reject;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    if (pop) begin
      dir_d    = mem_q[rd_ptr_q];
      rd_ptr_d = (rd_ptr_q == PMAX) ? '0 : rd_ptr_q + PW'(1);
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PMAX) ? '0 : wr_ptr_q + PW'(1);
    end
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (pop && !push) count_d = count_q - 3'd1;

    if (restart) begin
      dir_d    = INIT_DIR;
      step_d   = 1'b0;
      drop_d   = 1'b0;
      count_d  = 3'd0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dir_q    <= INIT_DIR;
      step_q   <= 1'b0;
      drop_q   <= 1'b0;
      count_q  <= 3'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: queue storage is not reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && !restart) mem_q[wr_ptr_q] <= key_dir;
  end

  assign dir     = dir_q;
  assign step    = step_q;
  assign drop    = drop_q;
  assign q_count = count_q;

endmodule
